// File: rtl/uart_rx_ext.sv
// uart_rx_ext: UART receiver with 3-sample majority voting, optional parity,
// 1 or 2 checked stop bits, and a first-word-fall-through receive FIFO.
//
// Ports:
//   clk           single clock for all logic
//   i_Rst_n       synchronous active-low reset
//   i_RX_Serial   asynchronous serial line, idles high
//   i_RD          pops the FIFO head on a clk edge while o_RX_DV=1
//   i_Clr_Ovr     clears o_Overrun (a same-cycle overrun set wins)
//   o_RX_DV       FIFO not empty
//   o_RX_Byte     FIFO head data, LSB = first received bit
//   o_Parity_Err  parity-error flag of the FIFO head entry
//   o_Frame_Err   framing-error flag of the FIFO head entry
//   o_Overrun     sticky: a frame was dropped because the FIFO was full
//   o_Busy        receive FSM is not in IDLE
module uart_rx_ext #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 i_Rst_n,
  input  logic                 i_RX_Serial,
  input  logic                 i_RD,
  input  logic                 i_Clr_Ovr,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int IW  = $clog2(DATA_BITS);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int MID = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] C_SAMP0 = CW'(MID - 1);
  localparam logic [CW-1:0] C_SAMP1 = CW'(MID);
  localparam logic [CW-1:0] C_VOTE  = CW'(MID + 1);
  localparam logic [CW-1:0] C_WRITE = CW'(MID + 2);
  localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] C_LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          C_LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          C_ODD       = 1'(PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 par_err;
    logic                 frm_err;
  } entry_t;

  state_t               r_state, w_state_nxt;
  logic                 r_rx_meta, r_rx_s;
  logic [CW-1:0]        r_clk_cnt;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_stop_idx;
  logic [1:0]           r_samp;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_err, r_frm_err;
  logic                 r_armed;
  logic                 w_maj, w_at_vote, w_bit_end, w_wr_req;

  entry_t               r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wptr, r_rptr;
  logic                 r_overrun;
  logic                 w_empty, w_full, w_rd, w_wr;
  entry_t               w_head;

  // Both flops preset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so the two flops form a real
      // shift chain; blocking would collapse them into one stage.
      r_rx_meta <= i_RX_Serial;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_maj     = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
  assign w_at_vote = (r_clk_cnt == C_VOTE);
  assign w_bit_end = (r_clk_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!i_Rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // branch would otherwise infer a latch.
    w_state_nxt = r_state;
    w_wr_req    = 1'b0;
    case (r_state)
      // r_armed is only set after a high line was seen in IDLE, so a break
      // that outlasts its frame cannot retrigger.
      S_IDLE:   if (r_armed && !r_rx_s) w_state_nxt = S_START;
      S_START: begin
        if (w_at_vote && w_maj) w_state_nxt = S_IDLE;
        else if (w_bit_end)     w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_bit_end && r_bit_idx == C_LAST_BIT)
          w_state_nxt = (PARITY == 0) ? S_STOP : S_PARITY;
      end
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
      // Commit one cycle after the last stop vote; the rest of the stop bit
      // is spent in IDLE so back-to-back frames are not missed.
      S_STOP: begin
        if (r_clk_cnt == C_WRITE && r_stop_idx == C_LAST_STOP) begin
          w_wr_req    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_samp     <= '0;
      r_shift    <= '0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      if (r_state == S_IDLE || w_bit_end) r_clk_cnt <= '0;
      else                                r_clk_cnt <= r_clk_cnt + 1'b1;
      if (r_clk_cnt == C_SAMP0) r_samp[0] <= r_rx_s;
      if (r_clk_cnt == C_SAMP1) r_samp[1] <= r_rx_s;
      case (r_state)
        S_IDLE: begin
          r_armed    <= r_rx_s;
          r_bit_idx  <= '0;
          r_stop_idx <= 1'b0;
          r_par_err  <= 1'b0;
          r_frm_err  <= 1'b0;
        end
        S_DATA: begin
          if (w_at_vote) r_shift   <= {w_maj, r_shift[DATA_BITS-1:1]};
          if (w_bit_end) r_bit_idx <= r_bit_idx + 1'b1;
        end
        S_PARITY: begin
          if (w_at_vote) r_par_err <= ((^r_shift) ^ w_maj) != C_ODD;
        end
        S_STOP: begin
          if (w_at_vote && !w_maj) r_frm_err  <= 1'b1;
          if (w_bit_end)           r_stop_idx <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_RD && !w_empty;
  assign w_wr    = w_wr_req && (!w_full || w_rd);

  // NOTE: storage is deliberately not reset; the pointers define validity and
  // the outputs are gated with w_empty so stale contents never show.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= '{data: r_shift, par_err: r_par_err, frm_err: r_frm_err};
  end

  always_ff @(posedge clk) begin
    if (!i_Rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      if (w_wr_req && !w_wr) r_overrun <= 1'b1;
      else if (i_Clr_Ovr)    r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rptr[AW-1:0]];
  assign o_RX_DV      = !w_empty;
  assign o_RX_Byte    = w_empty ? '0 : w_head.data;
  assign o_Parity_Err = !w_empty && w_head.par_err;
  assign o_Frame_Err  = !w_empty && w_head.frm_err;
  assign o_Overrun    = r_overrun;
  assign o_Busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
// Directed bench for uart_rx_ext: u_dut0 uses default parameters (8N1,
// 4-entry FIFO), u_dut1 uses even parity. Serial lines are driven and
// outputs sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx_ext;

  localparam int CPB = 217;
  localparam int MID = CPB / 2;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_n;
  logic       rx0, rd0, clr0, dv0, pe0, fe0, ovr0, busy0;
  logic [7:0] byte0;
  logic       rx1, rd1, clr1, dv1, pe1, fe1, ovr1, busy1;
  logic [7:0] byte1;

  int n_tests = 0;
  int n_fail  = 0;
  int g_lat;

  uart_rx_ext u_dut0 (
    .clk(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx0), .i_RD(rd0), .i_Clr_Ovr(clr0),
    .o_RX_DV(dv0), .o_RX_Byte(byte0), .o_Parity_Err(pe0), .o_Frame_Err(fe0),
    .o_Overrun(ovr0), .o_Busy(busy0)
  );

  uart_rx_ext #(.PARITY(2)) u_dut1 (
    .clk(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx1), .i_RD(rd1), .i_Clr_Ovr(clr1),
    .o_RX_DV(dv1), .o_RX_Byte(byte1), .o_Parity_Err(pe1), .o_Frame_Err(fe1),
    .o_Overrun(ovr1), .o_Busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input int clocks);
    if (sel) rx1 = v; else rx0 = v;
    repeat (clocks) @(negedge clk);
  endtask

  // Sends n bits LSB first, one bit period each; g_lat records the number of
  // clocks into the last bit at which o_RX_DV was first seen high (-1: never).
  task automatic send_frame(input bit sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n - 1; i++) drive_bit(sel, bits[i], CPB);
    if (sel) rx1 = bits[n-1]; else rx0 = bits[n-1];
    g_lat = -1;
    for (int c = 0; c < CPB; c++) begin
      @(negedge clk);
      if (g_lat < 0 && (sel ? dv1 : dv0)) g_lat = c + 1;
    end
    if (sel) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  task automatic pop_check(input bit sel, input string tag, input logic [7:0] b,
                           input logic pe, input logic fe);
    check({tag, "_dv"},   sel ? dv1 : dv0, 1);
    check({tag, "_byte"}, sel ? byte1 : byte0, b);
    check({tag, "_pe"},   sel ? pe1 : pe0, pe);
    check({tag, "_fe"},   sel ? fe1 : fe0, fe);
    if (sel) rd1 = 1'b1; else rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    rd1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx0 = 1'b1; rd0 = 1'b0; clr0 = 1'b0;
    rx1 = 1'b1; rd1 = 1'b0; clr1 = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state
    check("rst_dv",   dv0, 0);
    check("rst_byte", byte0, 0);
    check("rst_pe",   pe0, 0);
    check("rst_fe",   fe0, 0);
    check("rst_ovr",  ovr0, 0);
    check("rst_busy", busy0, 0);
    check("rst_dv1",  dv1, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", busy0, 0);

    // 8N1 byte 0x37 with write latency after the stop-bit middle
    send_frame(0, 16'({1'b1, 8'h37, 1'b0}), 10);
    check("x37_lat", 32'((g_lat >= MID) && (g_lat <= 2 * MID + 4)), 1);
    pop_check(0, "x37", 8'h37, 1'b0, 1'b0);
    check("x37_empty", dv0, 0);

    // Read while empty is ignored
    rd0 = 1'b1;
    @(negedge clk);
    rd0 = 1'b0;
    check("rd_empty_dv", dv0, 0);

    // Bad stop bit
    send_frame(0, 16'({1'b0, 8'h55, 1'b0}), 10);
    drive_bit(0, 1'b1, CPB);
    pop_check(0, "x55_stop0", 8'h55, 1'b0, 1'b1);

    // Break: low far longer than a frame delivers exactly one 0x00 entry
    drive_bit(0, 1'b0, 12 * CPB);
    drive_bit(0, 1'b1, 2 * CPB);
    pop_check(0, "break", 8'h00, 1'b0, 1'b1);
    check("break_single", dv0, 0);
    send_frame(0, 16'({1'b1, 8'h3C, 1'b0}), 10);
    pop_check(0, "x3C", 8'h3C, 1'b0, 1'b0);

    // 50-clock glitch on the idle line
    drive_bit(0, 1'b0, 10);
    check("glitch_busy_on", busy0, 1);
    drive_bit(0, 1'b0, 40);
    drive_bit(0, 1'b1, CPB);
    check("glitch_busy_off", busy0, 0);
    check("glitch_dv", dv0, 0);

    // Even parity: 0xA5 has four ones, so parity bit 1 is an error
    send_frame(1, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11);
    pop_check(1, "par_bad", 8'hA5, 1'b1, 1'b0);
    send_frame(1, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11);
    pop_check(1, "par_ok", 8'hA5, 1'b0, 1'b0);

    // FIFO fill and overrun
    for (int i = 1; i <= 4; i++) send_frame(0, 16'({1'b1, 8'(i), 1'b0}), 10);
    check("fifo_full_no_ovr", ovr0, 0);
    send_frame(0, 16'({1'b1, 8'h05, 1'b0}), 10);
    check("fifo_ovr_set", ovr0, 1);
    pop_check(0, "fifo0", 8'h01, 1'b0, 1'b0);
    pop_check(0, "fifo1", 8'h02, 1'b0, 1'b0);
    pop_check(0, "fifo2", 8'h03, 1'b0, 1'b0);
    pop_check(0, "fifo3", 8'h04, 1'b0, 1'b0);
    check("fifo_drained", dv0, 0);
    check("ovr_sticky", ovr0, 1);
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    check("ovr_cleared", ovr0, 0);

    // Reset in DATA bit 3 with an entry already queued
    send_frame(0, 16'({1'b1, 8'h5A, 1'b0}), 10);
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, CPB);
    drive_bit(0, 1'b0, CPB);
    drive_bit(0, 1'b1, CPB);
    drive_bit(0, 1'b0, MID);
    check("pre_rst_busy", busy0, 1);
    check("pre_rst_dv", dv0, 1);
    rst_n = 1'b0;
    rx0   = 1'b1;
    @(negedge clk);
    check("mid_rst_dv",   dv0, 0);
    check("mid_rst_byte", byte0, 0);
    check("mid_rst_busy", busy0, 0);
    check("mid_rst_fe",   fe0, 0);
    check("mid_rst_pe",   pe0, 0);
    check("mid_rst_ovr",  ovr0, 0);
    rst_n = 1'b1;
    drive_bit(0, 1'b1, 2 * CPB);
    check("post_rst_idle", busy0, 0);
    send_frame(0, 16'({1'b1, 8'hC3, 1'b0}), 10);
    pop_check(0, "xC3", 8'hC3, 1'b0, 1'b0);
    check("xC3_only", dv0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 217, clocks per bit (legal range 8..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked per frame (legal values 1 or 2).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (legal values: power of two, 2..64).
REQ-006 SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-007 SHALL have port i_Rst_n, input, 1 bit, synchronous active-low reset.
REQ-008 SHALL have port i_RX_Serial, input, 1 bit, asynchronous serial line that idles high.
REQ-009 SHALL have port i_RD, input, 1 bit, pops the FIFO head on a clk edge while o_RX_DV=1.
REQ-010 SHALL have port i_Clr_Ovr, input, 1 bit, clears o_Overrun.
REQ-011 SHALL have port o_RX_DV, output, 1 bit, high while the FIFO is not empty.
REQ-012 SHALL have port o_RX_Byte, output, DATA_BITS bits, FIFO head data, LSB = first received bit.
REQ-013 SHALL have port o_Parity_Err, output, 1 bit, parity-error flag of the FIFO head entry.
REQ-014 SHALL have port o_Frame_Err, output, 1 bit, framing-error flag of the FIFO head entry.
REQ-015 SHALL have port o_Overrun, output, 1 bit, sticky flag: a frame was dropped because the FIFO was full.
REQ-016 SHALL have port o_Busy, output, 1 bit, high while the receive FSM is not in IDLE.

Function
REQ-017 SHALL pass i_RX_Serial through a 2-flop synchronizer; all FSM logic SHALL use the synchronized value rx_s.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL, in IDLE, move to START when rx_s=0 and clear the clock counter.
REQ-020 SHALL sample each bit by majority vote of 3 samples, taken at clock counts MID-1, MID and MID+1 within the bit, where MID = CLKS_PER_BIT/2 (integer division).
REQ-021 SHALL treat a START majority of 1 as a glitch and return to IDLE without writing the FIFO.
REQ-022 SHALL, when the START majority is 0, wait until the counter reaches CLKS_PER_BIT-1, then enter DATA with bit index 0.
REQ-023 SHALL, in DATA, shift in DATA_BITS bits LSB first, one per CLKS_PER_BIT clocks.
REQ-024 SHALL, when PARITY=0, go from DATA straight to STOP, skipping PARITY.
REQ-025 SHALL, in PARITY, set the parity error when (XOR of data bits XOR received parity bit) != 1 for odd mode, or != 0 for even mode.
REQ-026 SHALL, in STOP, set the framing error if any checked stop-bit majority is 0.
REQ-027 SHALL, with STOP_BITS=2, check the second stop bit one bit period after the first.
REQ-028 SHALL, on the cycle after the last stop majority is resolved, write {data, parity err, frame err} to the FIFO and return to IDLE; no wait for the end of the stop bit.
REQ-029 SHALL make a written entry visible at o_RX_DV/o_RX_Byte on the cycle after the write (first-word fall-through).
REQ-030 SHALL drop the frame and set o_Overrun=1 when writing to a full FIFO, except when i_RD=1 in the same cycle, in which case the write SHALL be accepted.
REQ-031 SHALL ignore i_RD while the FIFO is empty, with no pointer change.
REQ-032 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and preserve order.
REQ-033 SHALL clear o_Overrun on i_Clr_Ovr=1; when a set and a clear occur in the same cycle, set SHALL win.
REQ-034 SHALL, when a break occurs (line low for the whole frame), deliver data 0x00 with the framing error set, and wait in IDLE for rx_s=1 before arming the next start detection.

Reset
REQ-035 SHALL, on a clk edge with i_Rst_n=0, clear the FSM to IDLE, the counters and FIFO pointers to 0, and o_RX_DV, o_Overrun, o_Busy, o_Parity_Err, o_Frame_Err, o_RX_Byte to 0.
REQ-036 SHALL preset both synchronizer flops to 1 on reset, so no false start occurs after reset.
REQ-037 SHALL, on reset mid-frame, discard the partial frame; the FIFO contents are lost.

Verification
REQ-038 SHALL cover: 40 ns clk, defaults (8N1), send 0x37 -> o_RX_DV=1 within CLKS_PER_BIT/2+4 clocks of the stop-bit middle, o_RX_Byte=0x37, both error flags 0.
REQ-039 SHALL cover: PARITY=2, send 0xA5 with parity bit 1 -> o_RX_Byte=0xA5, o_Parity_Err=1; with parity bit 0 -> o_Parity_Err=0.
REQ-040 SHALL cover: send 0x55 with stop bit 0 -> o_Frame_Err=1; an all-low break -> 0x00 with o_Frame_Err=1, and the next valid 0x3C is received cleanly.
REQ-041 SHALL cover: a 50-clock low glitch on the idle line -> o_Busy returns to 0, o_RX_DV stays 0.
REQ-042 SHALL cover: FIFO_DEPTH=4, send 0x01..0x05 without reads -> 0x01..0x04 popped in order, o_Overrun=1; i_Clr_Ovr pulse -> o_Overrun=0.
REQ-043 SHALL cover: i_Rst_n=0 during DATA bit 3 -> all outputs 0 the next cycle; a following 0xC3 frame is received correctly.
